// File: rtl/analog_pad_seq_pkg.sv
// Shared padframe definitions: sequencer state encoding and default timing constants.
package analog_pad_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StBreak,
        StMake,
        StSettle,
        StActive
    } pad_seq_state_e;

    localparam int unsigned BbmCycDefault    = 4;
    localparam int unsigned SettleCycDefault = 16;

endpackage

// File: rtl/analog_pad_seq.sv
// Break-before-make sequencer for the chip-side switches of a bank of analog pads.
// One pad at most is ever connected; a reselect opens everything, waits, closes, then settles.
module analog_pad_seq
    import analog_pad_seq_pkg::*;
#(
    parameter int unsigned NUM_PADS   = 8,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned BBM_CYC    = BbmCycDefault,
    parameter int unsigned SETTLE_CYC = SettleCycDefault
) (
    input  logic                pclk,
    input  logic                n_p_reset,
    input  logic                sel_req,
    input  logic [IDX_W-1:0]    sel_idx,
    input  logic                pad_dis,
    output logic [NUM_PADS-1:0] sw_en,
    output logic                busy,
    output logic                sel_ack,
    output logic                sel_err,
    output logic [IDX_W-1:0]    cur_idx
);

    localparam int unsigned CntMax = (BBM_CYC > SETTLE_CYC) ? BBM_CYC : SETTLE_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] BbmLoad    = CntW'(BBM_CYC - 1);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYC - 1);

    pad_seq_state_e      state_q;
    logic [CntW-1:0]     cnt_q;
    logic [IDX_W-1:0]    tgt_q;
    logic [IDX_W-1:0]    cur_idx_q;
    logic [NUM_PADS-1:0] sw_en_q;
    logic                busy_q;
    logic                sel_ack_q;
    logic                sel_err_q;

    logic                idx_ok;
    logic [NUM_PADS-1:0] tgt_onehot;

    assign idx_ok = (32'(sel_idx) < NUM_PADS);

    always_comb begin
        tgt_onehot = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (32'(tgt_q) == i) tgt_onehot[i] = 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            tgt_q     <= '0;
            cur_idx_q <= '0;
            sw_en_q   <= '0;
            busy_q    <= 1'b0;
            sel_ack_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            sel_ack_q <= 1'b0;
            sel_err_q <= 1'b0;
            // Disable overrides everything, including a request in the same cycle.
            if (pad_dis) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                sw_en_q <= '0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StActive: begin
                        if (sel_req) begin
                            if (!idx_ok) begin
                                sel_err_q <= 1'b1;
                            end else if (state_q == StActive && sel_idx == cur_idx_q) begin
                                sel_ack_q <= 1'b1;
                            end else begin
                                tgt_q   <= sel_idx;
                                sw_en_q <= '0;
                                busy_q  <= 1'b1;
                                cnt_q   <= BbmLoad;
                                state_q <= StBreak;
                            end
                        end
                    end
                    StBreak: begin
                        if (sel_req) sel_err_q <= 1'b1;
                        if (cnt_q == '0) state_q <= StMake;
                        else cnt_q <= cnt_q - 1'b1;
                    end
                    StMake: begin
                        if (sel_req) sel_err_q <= 1'b1;
                        sw_en_q   <= tgt_onehot;
                        cur_idx_q <= tgt_q;
                        cnt_q     <= SettleLoad;
                        state_q   <= StSettle;
                    end
                    StSettle: begin
                        if (sel_req) sel_err_q <= 1'b1;
                        if (cnt_q == '0) begin
                            state_q   <= StActive;
                            busy_q    <= 1'b0;
                            sel_ack_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        sw_en_q <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sw_en   = sw_en_q;
    assign busy    = busy_q;
    assign sel_ack = sel_ack_q;
    assign sel_err = sel_err_q;
    assign cur_idx = cur_idx_q;

endmodule

// File: tb/tb_analog_pad_seq.sv
// Directed bench for analog_pad_seq with six pads, so out-of-range indices are reachable.
module tb_analog_pad_seq;

    localparam int NP = 6;
    localparam int IW = 3;

    logic          pclk      = 1'b0;
    logic          n_p_reset = 1'b0;
    logic          sel_req   = 1'b0;
    logic          pad_dis   = 1'b0;
    logic [IW-1:0] sel_idx   = '0;
    logic [NP-1:0] sw_en;
    logic          busy;
    logic          sel_ack;
    logic          sel_err;
    logic [IW-1:0] cur_idx;

    int passed = 0;
    int total  = 0;

    always #5 pclk = ~pclk;

    analog_pad_seq #(
        .NUM_PADS  (NP),
        .IDX_W     (IW),
        .BBM_CYC   (4),
        .SETTLE_CYC(16)
    ) dut (
        .pclk     (pclk),
        .n_p_reset(n_p_reset),
        .sel_req  (sel_req),
        .sel_idx  (sel_idx),
        .pad_dis  (pad_dis),
        .sw_en    (sw_en),
        .busy     (busy),
        .sel_ack  (sel_ack),
        .sel_err  (sel_err),
        .cur_idx  (cur_idx)
    );

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Request lives in cycle 0; returns in cycle 1.
    task automatic request(input logic [IW-1:0] idx);
        sel_req = 1'b1;
        sel_idx = idx;
        step();
        sel_req = 1'b0;
    endtask

    task automatic test_reset();
        n_p_reset = 1'b0;
        step();
        step();
        total++;
        if ({sw_en, busy, sel_ack, sel_err, cur_idx} !== '0) begin
            $display("FAIL reset_outputs: got sw_en=%h busy=%b ack=%b err=%b cur=%0d, want all 0",
                     sw_en, busy, sel_ack, sel_err, cur_idx);
        end else passed++;
        #2 n_p_reset = 1'b1;
        step();
        total++;
        if ({sw_en, busy} !== '0) begin
            $display("FAIL post_reset_idle: got sw_en=%h busy=%b, want 0 0", sw_en, busy);
        end else passed++;
    endtask

    // Full sequence to pad idx; err_a/err_b are cycles whose sel_req gets a rejected request.
    task automatic run_sequence(input string name, input logic [IW-1:0] idx,
                                input int err_a, input int err_b);
        logic [NP-1:0] pad_bit;
        logic [NP-1:0] exp_sw;
        pad_bit = '0;
        pad_bit[idx] = 1'b1;
        request(idx);
        for (int k = 1; k <= 22; k++) begin
            exp_sw = (k >= 6) ? pad_bit : '0;
            total++;
            if ({sw_en, busy, sel_ack, sel_err} !==
                {exp_sw, (k <= 21), (k == 22), (k == err_a + 1 || k == err_b + 1)}) begin
                $display("FAIL %s_cyc%0d: got sw_en=%h busy=%b ack=%b err=%b, want %h %b %b %b",
                         name, k, sw_en, busy, sel_ack, sel_err, exp_sw, (k <= 21), (k == 22),
                         (k == err_a + 1 || k == err_b + 1));
            end else passed++;
            total++;
            if ($countones(sw_en) > 1) begin
                $display("FAIL %s_onehot%0d: got sw_en=%h, want at most one bit", name, k, sw_en);
            end else passed++;
            if (k < 22) begin
                if (k == err_a || k == err_b) begin
                    sel_req = 1'b1;
                    sel_idx = 3'd3;
                end
                step();
                sel_req = 1'b0;
            end
        end
        total++;
        if (cur_idx !== idx) begin
            $display("FAIL %s_cur_idx: got %0d, want %0d", name, cur_idx, idx);
        end else passed++;
        step();
        total++;
        if ({sel_ack, busy} !== 2'b00) begin
            $display("FAIL %s_ack_pulse: got ack=%b busy=%b, want 0 0", name, sel_ack, busy);
        end else passed++;
    endtask

    task automatic test_first_select();
        run_sequence("first_sel2", 3'd2, -5, -5);
    endtask

    task automatic test_switch();
        run_sequence("switch_2to5", 3'd5, -5, -5);
    endtask

    task automatic test_same_pad();
        request(3'd5);
        total++;
        if ({sel_ack, sel_err, busy, sw_en} !== {3'b100, 6'h20}) begin
            $display("FAIL same_pad_ack: got ack=%b err=%b busy=%b sw_en=%h, want 1 0 0 20",
                     sel_ack, sel_err, busy, sw_en);
        end else passed++;
        step();
        total++;
        if ({sel_ack, sw_en} !== {1'b0, 6'h20}) begin
            $display("FAIL same_pad_after: got ack=%b sw_en=%h, want 0 20", sel_ack, sw_en);
        end else passed++;
    endtask

    task automatic test_bad_index();
        logic [IW-1:0] bad;
        for (int b = 6; b <= 7; b++) begin
            bad = IW'(b);
            request(bad);
            total++;
            if ({sel_err, sel_ack, busy, sw_en} !== {3'b100, 6'h20}) begin
                $display("FAIL bad_idx%0d: got err=%b ack=%b busy=%b sw_en=%h, want 1 0 0 20",
                         b, sel_err, sel_ack, busy, sw_en);
            end else passed++;
            step();
            total++;
            if ({sel_err, sw_en, cur_idx} !== {1'b0, 6'h20, 3'd5}) begin
                $display("FAIL bad_idx%0d_after: got err=%b sw_en=%h cur=%0d, want 0 20 5",
                         b, sel_err, sw_en, cur_idx);
            end else passed++;
        end
        // Still ACTIVE on pad 5: same-pad request is acked at once.
        request(3'd5);
        total++;
        if ({sel_ack, busy} !== 2'b10) begin
            $display("FAIL bad_idx_state_kept: got ack=%b busy=%b, want 1 0", sel_ack, busy);
        end else passed++;
    endtask

    task automatic test_req_in_sequence();
        run_sequence("busy_req", 3'd2, 3, 8);
    endtask

    task automatic test_pad_dis();
        request(3'd5);
        for (int k = 1; k < 10; k++) step();
        total++;
        if ({sw_en, busy} !== {6'h20, 1'b1}) begin
            $display("FAIL dis_pre_settle: got sw_en=%h busy=%b, want 20 1", sw_en, busy);
        end else passed++;
        pad_dis = 1'b1;
        sel_req = 1'b1;
        sel_idx = 3'd1;
        step();
        total++;
        if ({sw_en, busy, sel_ack, sel_err} !== '0) begin
            $display("FAIL dis_abort: got sw_en=%h busy=%b ack=%b err=%b, want 0 0 0 0",
                     sw_en, busy, sel_ack, sel_err);
        end else passed++;
        step();
        total++;
        if ({sw_en, busy, sel_err} !== '0) begin
            $display("FAIL dis_hold: got sw_en=%h busy=%b err=%b, want 0 0 0",
                     sw_en, busy, sel_err);
        end else passed++;
        pad_dis = 1'b0;
        sel_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            total++;
            if ({sw_en, busy, sel_ack, sel_err} !== '0) begin
                $display("FAIL dis_quiet%0d: got sw_en=%h busy=%b ack=%b err=%b, want 0",
                         k, sw_en, busy, sel_ack, sel_err);
            end else passed++;
        end
        // In IDLE, even the previous index starts a full sequence.
        run_sequence("after_dis", 3'd5, -5, -5);
    endtask

    task automatic test_async_reset();
        request(3'd3);
        step();
        step();
        total++;
        if ({busy, sw_en} !== {1'b1, 6'h00}) begin
            $display("FAIL rst_mid_break_pre: got busy=%b sw_en=%h, want 1 00", busy, sw_en);
        end else passed++;
        #2 n_p_reset = 1'b0;
        #1;
        total++;
        if ({sw_en, busy, sel_ack, sel_err, cur_idx} !== '0) begin
            $display("FAIL rst_async: got sw_en=%h busy=%b ack=%b err=%b cur=%0d, want all 0",
                     sw_en, busy, sel_ack, sel_err, cur_idx);
        end else passed++;
        #3 n_p_reset = 1'b1;
        step();
        total++;
        if ({sw_en, busy, sel_ack} !== '0) begin
            $display("FAIL rst_release_idle: got sw_en=%h busy=%b ack=%b, want 0",
                     sw_en, busy, sel_ack);
        end else passed++;
        run_sequence("after_rst", 3'd3, -5, -5);
    endtask

    initial begin
        test_reset();
        test_first_select();
        test_switch();
        test_same_pad();
        test_bad_index();
        test_req_in_sequence();
        test_pad_dis();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
